// File: rtl/nn_upscaler_stream.sv
// Streaming nearest-neighbour 4->5 upscaler: every 4th column and row is emitted twice.
// Rows needing replication are replayed from a single row-sized line buffer.
module nn_upscaler_stream #(
  parameter int IN_W = 128,
  parameter int IN_H = 96
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_pixel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_pixel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof
);
  localparam int OUT_W = IN_W * 5 / 4;
  localparam int OUT_H = IN_H * 5 / 4;
  localparam int CW    = $clog2(IN_W);
  localparam int RW    = $clog2(IN_H);
  localparam int OCW   = $clog2(OUT_W);
  localparam int ORW   = $clog2(OUT_H);

  typedef enum logic {PASS, REPLAY} state_t;

  state_t         state;
  logic           dup;
  logic           rep_pend;
  logic [CW-1:0]  in_col;
  logic [CW-1:0]  rd_col;
  logic [RW-1:0]  in_row;
  logic [OCW-1:0] out_col;
  logic [ORW-1:0] out_row;
  logic [7:0]     linebuf [IN_W];

  logic       slot;
  logic       accept;
  logic       load;
  logic [7:0] load_pix;
  logic       col_last;
  logic       row_last;

  assign slot     = !out_valid || out_ready;
  assign in_ready = reset_n && slot && !dup && (state == PASS);
  assign accept   = in_valid && in_ready;
  assign col_last = (out_col == OCW'(OUT_W - 1));
  assign row_last = (out_row == ORW'(OUT_H - 1));

  // A duplicate in PASS re-emits the value still sitting in the output register.
  always_comb begin
    load     = 1'b0;
    load_pix = out_pixel;
    if (slot) begin
      if (state == REPLAY) begin
        load     = 1'b1;
        load_pix = linebuf[rd_col];
      end else if (dup) begin
        load = 1'b1;
      end else if (accept) begin
        load     = 1'b1;
        load_pix = in_pixel;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) linebuf[in_col] <= in_pixel;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PASS;
      dup       <= 1'b0;
      rep_pend  <= 1'b0;
      in_col    <= '0;
      in_row    <= '0;
      rd_col    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      out_pixel <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      if (load) begin
        out_pixel <= load_pix;
        out_valid <= 1'b1;
        out_sof   <= (out_col == '0) && (out_row == '0);
        out_eol   <= col_last;
        out_eof   <= col_last && row_last;
        if (col_last) begin
          out_col <= '0;
          out_row <= row_last ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end else if (slot) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (in_col[1:0] == 2'd3) dup <= 1'b1;
        if (in_col == CW'(IN_W - 1)) begin
          in_col <= '0;
          in_row <= (in_row == RW'(IN_H - 1)) ? '0 : in_row + 1'b1;
          if (in_row[1:0] == 2'd3) rep_pend <= 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end

      // The duplicate of the last column closes the row; replay follows if this row repeats.
      if (load && state == PASS && dup) begin
        dup <= 1'b0;
        if (col_last && rep_pend) begin
          state    <= REPLAY;
          rep_pend <= 1'b0;
        end
      end

      if (load && state == REPLAY) begin
        if (rd_col[1:0] == 2'd3 && !dup) begin
          dup <= 1'b1;
        end else begin
          dup <= 1'b0;
          if (rd_col == CW'(IN_W - 1)) begin
            rd_col <= '0;
            state  <= PASS;
          end else begin
            rd_col <= rd_col + 1'b1;
          end
        end
      end
    end
  end
endmodule
